// File: rtl/modular_square_sequencer.sv
// ---------------------------------------------------------------------------
// modular_square_sequencer
//
// Control-only sequencer for a multi-cycle modular squaring datapath that
// computes x -> x^2 mod N repeatedly, T times.  The operands themselves live
// in the datapath; this block only decides when the datapath captures them.
//
// A job is accepted on the start valid/ready handshake.  After that, the
// block waits SQ_LATENCY cycles for each squaring and then strobes the
// datapath: feedback between iterations, and output capture after the last
// one.  The finished result is then offered on the done valid/ready
// handshake.  Abort cancels a running or finished job.
//
// Parameters
//   SQ_LATENCY  cycles from an operand capture edge to a stable result (>= 1)
//   ITER_W      width of the iteration count and counters
//
// Ports
//   clk             clock
//   reset           asynchronous, active-high reset
//   start_valid     job request
//   start_ready     controller can accept a job (idle and not aborting)
//   start_iters     number of squarings T, sampled on accept (0 means 1)
//   abort           cancel the current job
//   dp_load         datapath loads the external start value
//   dp_feedback     datapath feeds its reduced result back as next operand
//   dp_out_capture  datapath latches the reduced result into its output reg
//   busy            controller is not idle
//   iter_count      iterations completed in the current/last job
//   done_valid      final result is held in the datapath output register
//   done_ready      consumer accepts the result
// ---------------------------------------------------------------------------
module modular_square_sequencer #(
    parameter int SQ_LATENCY = 5,
    parameter int ITER_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ITER_W-1:0] start_iters,
    input  logic              abort,
    output logic              dp_load,
    output logic              dp_feedback,
    output logic              dp_out_capture,
    output logic              busy,
    output logic [ITER_W-1:0] iter_count,
    output logic              done_valid,
    input  logic              done_ready
);

    localparam int                LAT_W      = (SQ_LATENCY > 1) ? $clog2(SQ_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_RELOAD = LAT_W'(SQ_LATENCY - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE    = LAT_W'(1);
    localparam logic [ITER_W-1:0] ITER_ONE   = ITER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [ITER_W-1:0]  r_target;
    logic [ITER_W-1:0]  r_iter_count;

    logic               w_accept;
    logic               w_iter_end;
    logic               w_last;
    logic [ITER_W-1:0]  w_iter_next;

    // Abort in IDLE only blocks acceptance; it never changes state there.
    assign start_ready = (r_state == S_IDLE) && !abort;

    // Gating with reset keeps dp_load quiet while the block is held in reset.
    assign w_accept    = start_valid && start_ready && !reset;

    // iter_count never exceeds target, so the increment cannot wrap even
    // when target is the all-ones value.
    assign w_iter_next = r_iter_count + ITER_ONE;
    assign w_iter_end  = (r_state == S_RUN) && (r_lat_cnt == '0);
    assign w_last      = (w_iter_next == r_target);

    // Strobes are pure decodes; abort wins over feedback and capture.
    assign dp_load        = w_accept;
    assign dp_feedback    = w_iter_end && !abort && !w_last;
    assign dp_out_capture = w_iter_end && !abort && w_last;

    assign busy       = (r_state != S_IDLE);
    assign done_valid = (r_state == S_DONE) && !abort;
    assign iter_count = r_iter_count;

    // Main sequencing FSM.  lat_cnt counts down the squaring latency; the
    // cycle in which it reaches zero is the last cycle of an iteration, where
    // the datapath result is stable and gets fed back or captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= '0;
            r_target     <= '0;
            r_iter_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_target     <= (start_iters == '0) ? ITER_ONE : start_iters;
                        r_iter_count <= '0;
                        r_lat_cnt    <= LAT_RELOAD;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - LAT_ONE;
                    end else begin
                        r_iter_count <= w_iter_next;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_lat_cnt <= LAT_RELOAD;
                        end
                    end
                end
                S_DONE: begin
                    if (abort || done_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modular_square_sequencer.sv
// ---------------------------------------------------------------------------
// tb_modular_square_sequencer
//
// Self-checking bench for modular_square_sequencer.  Two instances are used:
// one with SQ_LATENCY=5 / ITER_W=64 and one with SQ_LATENCY=1 / ITER_W=8, the
// narrow one allowing a full run with the all-ones iteration count.  Only
// one instance runs a job at a time; 'sel' chooses which.
//
// The expected outputs of every cycle come from a timeline model: relative
// to the accept cycle, iteration k ends at cycle k*L, feedback is strobed at
// every multiple of L below T*L, capture at T*L, and the result is offered
// from T*L+1 until the done handshake.
// ---------------------------------------------------------------------------
module tb_modular_square_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic [63:0] start_iters;
    logic        abort;
    logic        done_ready;
    logic        sel;

    logic        sr5, ld5, fb5, cp5, busy5, dv5;
    logic [63:0] ic5;
    logic        sr1, ld1, fb1, cp1, busy1, dv1;
    logic [7:0]  ic1;

    logic [69:0] obs;

    int          testCount = 0;
    int          failCount = 0;
    int          jobId     = 0;
    longint unsigned lastCount5 = 0;
    longint unsigned lastCount1 = 0;

    always #5 clk = ~clk;

    modular_square_sequencer #(.SQ_LATENCY(5), .ITER_W(64)) dut5 (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid & ~sel),
        .start_ready    (sr5),
        .start_iters    (start_iters),
        .abort          (abort),
        .dp_load        (ld5),
        .dp_feedback    (fb5),
        .dp_out_capture (cp5),
        .busy           (busy5),
        .iter_count     (ic5),
        .done_valid     (dv5),
        .done_ready     (done_ready)
    );

    modular_square_sequencer #(.SQ_LATENCY(1), .ITER_W(8)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid & sel),
        .start_ready    (sr1),
        .start_iters    (start_iters[7:0]),
        .abort          (abort),
        .dp_load        (ld1),
        .dp_feedback    (fb1),
        .dp_out_capture (cp1),
        .busy           (busy1),
        .iter_count     (ic1),
        .done_valid     (dv1),
        .done_ready     (done_ready)
    );

    // Observed bundle of the selected instance:
    // {start_ready, busy, done_valid, dp_load, dp_feedback, dp_out_capture, iter_count}
    always_comb begin
        obs = '0;
        if (sel)
            obs = {sr1, busy1, dv1, ld1, fb1, cp1, 56'd0, ic1};
        else
            obs = {sr5, busy5, dv5, ld5, fb5, cp5, ic5};
    end

    function automatic logic [69:0] mk(input bit sr, input bit bs, input bit dv,
                                       input bit ld, input bit fb, input bit cp,
                                       input longint unsigned cnt);
        return {sr, bs, dv, ld, fb, cp, 64'(cnt)};
    endfunction

    task automatic checkOutput(input string tag, input logic [69:0] got, input logic [69:0] exp);
        testCount++;
        assert (got === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Run one job on the selected instance from its accept cycle until the
    // done handshake or abort, checking every cycle against the timeline.
    task automatic applyStimulus(input bit s, input int L, input longint unsigned T,
                                 input int readyWait, input int abortAt);
        longint unsigned teff;
        longint unsigned endC;
        longint unsigned cnt;
        longint unsigned prev;
        bit              finished;
        bit              ab;
        bit              inDone;
        bit              fb;
        bit              cp;
        bit              dr;
        longint          n;

        teff     = (T == 0) ? 1 : T;
        endC     = teff * longint'(L);
        prev     = s ? lastCount1 : lastCount5;
        finished = 1'b0;
        cnt      = 0;
        jobId++;

        @(negedge clk);
        sel         = s;
        start_valid = 1'b1;
        start_iters = 64'(T);
        abort       = 1'b0;
        done_ready  = 1'b0;
        #1;
        checkOutput($sformatf("job%0d accept", jobId), obs, mk(1, 0, 0, 1, 0, 0, prev));
        @(posedge clk);

        n = 1;
        while (!finished && n <= longint'(endC) + readyWait + 20) begin
            @(negedge clk);
            ab          = (n == abortAt);
            inDone      = (n > longint'(endC));
            dr          = inDone ? (n >= longint'(endC) + 1 + readyWait) : 1'($urandom);
            start_valid = 1'($urandom);
            start_iters = {$urandom, $urandom};
            abort       = ab;
            done_ready  = dr;
            if (!inDone) begin
                fb  = !ab && (n % L == 0) && (n < longint'(endC));
                cp  = !ab && (n == longint'(endC));
                cnt = longint'(unsigned'((n - 1) / L));
                #1;
                checkOutput($sformatf("job%0d run n%0d", jobId, n), obs, mk(0, 1, 0, 0, fb, cp, cnt));
            end else begin
                cnt = teff;
                #1;
                checkOutput($sformatf("job%0d done n%0d", jobId, n), obs, mk(0, 1, !ab, 0, 0, 0, cnt));
            end
            @(posedge clk);
            if (ab || (inDone && dr))
                finished = 1'b1;
            n++;
        end

        testCount++;
        assert (finished) else begin
            failCount++;
            $error("[TB] FAIL job%0d timeout: finished %0d required 1", jobId, finished);
        end

        if (s) lastCount1 = cnt; else lastCount5 = cnt;
        #1;
        done_ready  = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
    endtask

    initial begin
        int              L;
        longint unsigned T;
        int              rw;
        int              ab;
        int              span;

        sel         = 1'b0;
        start_valid = 1'b0;
        start_iters = '0;
        abort       = 1'b1;
        done_ready  = 1'b0;
        reset       = 1'b1;

        // Reset values; start_ready follows !abort even in reset.
        #2;
        checkOutput("reset abort=1", obs, mk(0, 0, 0, 0, 0, 0, 0));
        abort = 1'b0;
        #1;
        checkOutput("reset abort=0", obs, mk(1, 0, 0, 0, 0, 0, 0));
        start_valid = 1'b1;
        #1;
        checkOutput("reset no load", obs, mk(1, 0, 0, 0, 0, 0, 0));
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed jobs from the timing examples.
        applyStimulus(0, 5, 3, 0, -1);
        applyStimulus(0, 5, 0, 0, -1);
        applyStimulus(1, 1, 4, 0, -1);
        applyStimulus(0, 5, 2, 10, -1);
        applyStimulus(0, 5, 3, 0, 7);
        applyStimulus(1, 1, 255, 2, -1);
        applyStimulus(1, 1, 0, 1, -1);
        applyStimulus(0, 5, 2, 3, 12);

        // Abort together with start_valid in IDLE must not accept.
        @(negedge clk);
        sel         = 1'b0;
        start_valid = 1'b1;
        start_iters = 64'd2;
        abort       = 1'b1;
        #1;
        checkOutput("idle abort blocks", obs, mk(0, 0, 0, 0, 0, 0, lastCount5));
        @(negedge clk);
        start_valid = 1'b0;
        abort       = 1'b0;
        #1;
        checkOutput("idle after abort", obs, mk(1, 0, 0, 0, 0, 0, lastCount5));

        // Reset pulsed at cycle 3 of a job, then a fresh full job.
        @(negedge clk);
        start_valid = 1'b1;
        start_iters = 64'd3;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("pre-reset run", obs, mk(0, 1, 0, 0, 0, 0, 0));
        reset = 1'b1;
        #1;
        checkOutput("async reset", obs, mk(1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        checkOutput("held reset", obs, mk(1, 0, 0, 0, 0, 0, 0));
        reset      = 1'b0;
        lastCount5 = 0;
        lastCount1 = 0;
        applyStimulus(0, 5, 3, 0, -1);

        // Randomized jobs on both instances.
        for (int i = 0; i < 16; i++) begin
            L    = (i % 2 == 0) ? 5 : 1;
            T    = longint'($urandom_range(0, 7));
            rw   = int'($urandom_range(0, 4));
            span = int'(((T == 0) ? 1 : T) * longint'(L)) + rw + 1;
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, span)) : -1;
            applyStimulus(L == 1, L, T, rw, ab);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
